aes_round_ctrl: RTL and testbench

//   Iterative AES round sequencer: accepts one 128-bit block, requests round

---
 rtl/aes_round_ctrl.sv | 96 +++++++++
 tb/tb_aes_round_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: loads one block, walks round keys 0..NR through a
// shared combinational round datapath, then holds the ciphertext until accepted.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          key_req,
  output logic [RW-1:0] key_idx,
  input  logic          key_valid,
  input  logic [127:0]  key_data,
  output logic [127:0]  dp_state,
  output logic [127:0]  dp_key,
  output logic          dp_final,
  input  logic [127:0]  dp_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic [RW-1:0] round,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, KEY, DONE} fsm_t;

  fsm_t          fsm, fsm_next;
  logic [127:0]  state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic          last_round;

  assign last_round = (round_q == RW'(NR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm     <= fsm_next;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Round 0 is the bare AddRoundKey; every later round takes the datapath result.
  // The counter stops at NR and only returns to 0 when the result is accepted.
  always_comb begin
    fsm_next  = fsm;
    state_d   = state_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    key_req   = 1'b0;
    key_idx   = '0;
    dp_final  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d  = in_data;
          round_d  = '0;
          fsm_next = KEY;
        end
      end
      KEY: begin
        key_req  = 1'b1;
        key_idx  = round_q;
        dp_final = last_round;
        if (key_valid) begin
          state_d = (round_q == '0) ? (state_q ^ key_data) : dp_result;
          if (last_round) fsm_next = DONE;
          else            round_d  = round_q + RW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_next = IDLE;
          round_d  = '0;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign dp_state = state_q;
  assign dp_key   = key_data;
  assign out_data = state_q;
  assign round    = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: XOR stub datapath for sequencing checks and a
// behavioural AES-128 round/key model for the FIPS-197 vector.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic          key_req;
  logic [RW-1:0] key_idx;
  logic          key_valid;
  logic [127:0]  key_data;
  logic [127:0]  dp_state;
  logic [127:0]  dp_key;
  logic          dp_final;
  logic [127:0]  dp_result;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic [RW-1:0] round;
  logic          busy;

  int tests = 0;
  int fails = 0;
  logic          use_aes = 1'b0;
  logic [127:0]  rk [0:15];

  aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .key_req(key_req), .key_idx(key_idx),
    .key_valid(key_valid), .key_data(key_data), .dp_state(dp_state),
    .dp_key(dp_key), .dp_final(dp_final), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .round(round), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] sq = x;
    logic [7:0] b;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [127:0] t, u;
    logic [7:0] a0, a1, a2, a3;
    for (int b = 0; b < 16; b++) t[8*b +: 8] = sbox(s[8*b +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        u[8*(4*c+r) +: 8] = t[8*(4*((c+r)%4)+r) +: 8];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = u[32*c +: 8]; a1 = u[32*c+8 +: 8]; a2 = u[32*c+16 +: 8]; a3 = u[32*c+24 +: 8];
        u[32*c    +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        u[32*c+8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        u[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        u[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    return u ^ k;
  endfunction

  always_comb begin
    key_data  = use_aes ? rk[key_idx] : {124'b0, key_idx};
    dp_result = use_aes ? aes_round(dp_state, dp_key, dp_final) : (dp_state ^ dp_key);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full block from IDLE: optional key stall at round stall_at, optional DONE hold.
  task automatic run_block(input string tag, input logic [127:0] data, input logic [127:0] expd,
                           input int stall_at, input int stall_len, input int done_hold);
    int n = 1;
    int exp_idx = 0;
    int stalls = 0;
    logic prev_stall = 1'b0;
    logic [127:0] held = '0;
    check({tag, " in_ready idle"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data  = data;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~data;
    while (out_valid !== 1'b1 && n < 60) begin
      check($sformatf("%s key_req n%0d", tag, n), 128'(key_req), 128'(1));
      check($sformatf("%s key_idx n%0d", tag, n), 128'(key_idx), 128'(exp_idx));
      check($sformatf("%s dp_final n%0d", tag, n), 128'(dp_final), 128'(exp_idx == NR));
      if (prev_stall) check($sformatf("%s held n%0d", tag, n), dp_state, held);
      if (exp_idx == stall_at && stalls < stall_len) begin
        key_valid  = 1'b0;
        held       = dp_state;
        prev_stall = 1'b1;
        stalls++;
      end else begin
        key_valid  = 1'b1;
        prev_stall = 1'b0;
        exp_idx++;
      end
      @(negedge clk);
      n++;
    end
    key_valid = 1'b1;
    check({tag, " latency"}, 128'(n), 128'(12 + stall_len));
    check({tag, " out_valid"}, 128'(out_valid), 128'(1));
    check({tag, " out_data"}, out_data, expd);
    check({tag, " round NR"}, 128'(round), 128'(NR));
    check({tag, " busy done"}, 128'(busy), 128'(1));
    for (int i = 0; i < done_hold; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = ~data;
      @(negedge clk);
      check($sformatf("%s hold valid %0d", tag, i), 128'(out_valid), 128'(1));
      check($sformatf("%s hold data %0d", tag, i), out_data, expd);
      check($sformatf("%s hold in_ready %0d", tag, i), 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " back idle"}, 128'(in_ready), 128'(1));
    check({tag, " out_valid low"}, 128'(out_valid), 128'(0));
    check({tag, " round cleared"}, 128'(round), 128'(0));
    check({tag, " state kept"}, dp_state, expd);
  endtask

  initial begin
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [127:0] key;
    logic [127:0] a_blk, b_blk;
    int n;

    key = 128'h0f0e0d0c0b0a09080706050403020100;
    rc  = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t[7:0] = t[7:0] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= NR) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
      else         rk[r] = '0;
    end

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; key_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("rst in_ready", 128'(in_ready), 128'(1));
    check("rst key_req", 128'(key_req), 128'(0));
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst out_data", out_data, '0);
    check("rst busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    a_blk = 128'h0123456789abcdeffedcba9876543210;
    run_block("stub", a_blk, a_blk ^ 128'hb, -1, 0, 0);
    run_block("stall", 128'hdeadbeef00000000cafef00d12345678, 128'hdeadbeef00000000cafef00d12345673, 5, 3, 0);
    run_block("hold", 128'h00000000000000000000000000000000, 128'hb, -1, 0, 4);

    // Reset while the block is in round 4
    in_valid = 1'b1;
    in_data  = a_blk;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (key_idx !== 4'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid round reached", 128'(key_idx), 128'(4));
    rst_n = 1'b0;
    #1;
    check("mid rst in_ready", 128'(in_ready), 128'(1));
    check("mid rst key_req", 128'(key_req), 128'(0));
    check("mid rst key_idx", 128'(key_idx), 128'(0));
    check("mid rst dp_final", 128'(dp_final), 128'(0));
    check("mid rst out_valid", 128'(out_valid), 128'(0));
    check("mid rst out_data", out_data, '0);
    check("mid rst busy", 128'(busy), 128'(0));
    check("mid rst round", 128'(round), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block("after rst", ~a_blk, ~a_blk ^ 128'hb, -1, 0, 0);

    // Back-to-back with in_valid held high
    a_blk = 128'h11112222333344445555666677778888;
    b_blk = 128'h9999aaaabbbbccccddddeeeeffff0000;
    in_valid = 1'b1; in_data = a_blk; out_ready = 1'b1;
    @(negedge clk);
    in_data = b_blk;
    n = 1;
    while (out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("b2b first latency", 128'(n), 128'(12));
    check("b2b first data", out_data, a_blk ^ 128'hb);
    @(negedge clk);
    n++;
    check("b2b bubble in_ready", 128'(in_ready), 128'(1));
    check("b2b bubble busy", 128'(busy), 128'(0));
    @(negedge clk);
    n++;
    in_valid = 1'b0;
    check("b2b second key_idx", 128'(key_idx), 128'(0));
    check("b2b second busy", 128'(busy), 128'(1));
    while (out_valid !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("b2b second latency", 128'(n), 128'(25));
    check("b2b second data", out_data, b_blk ^ 128'hb);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b idle", 128'(in_ready), 128'(1));

    use_aes = 1'b1;
    run_block("fips", 128'hffeeddccbbaa99887766554433221100,
              128'h5ac5b47080b7cdd830047b6ad8e0c469, -1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

endmodule
